// File: rtl/i2c_master_controller_if.sv
// ============================================================================
// Module : i2c_master_controller_if
// Brief  : System-side request/response handshake of the I2C master controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2c_master_controller_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;

    // Requester side (system / testbench)
    modport master (
        output start, rw, addr, wdata,
        input  rdata, busy, done, ack_err
    );

    // Responder side (the controller)
    modport slave (
        input  start, rw, addr, wdata,
        output rdata, busy, done, ack_err
    );
endinterface

`default_nettype wire

// File: rtl/i2c_master_controller.sv
// ============================================================================
// Module : i2c_master_controller
// Brief  : Single-master I2C controller for single-byte write/read transfers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_master_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    i2c_master_controller_if.slave    req,
    output logic                      SCL,
    inout  wire                       SDA
);

    localparam int                c_qw   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_qw-1:0]   c_qmax = c_qw'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WR       = 4'd4,
        ST_WR_ACK   = 4'd5,
        ST_RD       = 4'd6,
        ST_RD_NACK  = 4'd7,
        ST_STOP     = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [c_qw-1:0] qcnt_q, qcnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            rw_q, rw_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            scl_q, scl_d;
    logic            sda_oe_q, sda_oe_d;

    logic            w_qtick;
    logic            w_sda_in;
    logic            w_bit_end;
    logic [7:0]      w_tx_byte;

    assign w_qtick   = busy_q && (qcnt_q == c_qmax);
    assign w_bit_end = w_qtick && (phase_q == 2'd3);
    assign w_sda_in  = SDA;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        qcnt_d    = '0;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shreg_d   = shreg_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;
        w_tx_byte = 8'h00;

        if (busy_q) begin
            qcnt_d = w_qtick ? '0 : qcnt_q + 1'b1;
        end
        if (w_qtick) begin
            phase_d = phase_q + 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // A request coinciding with the done pulse is deliberately dropped.
                if (req.start && !done_q) begin
                    rw_d      = req.rw;
                    addr_d    = req.addr;
                    wdata_d   = req.wdata;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    phase_d   = 2'd0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    bit_cnt_d = 3'd7;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR, ST_WR, ST_RD: begin
                if (state_q == ST_RD && w_qtick && phase_q == 2'd2) begin
                    shreg_d = {shreg_q[6:0], w_sda_in};
                end
                if (w_bit_end) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK :
                                  (state_q == ST_WR)   ? ST_WR_ACK   : ST_RD_NACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            ST_ADDR_ACK, ST_WR_ACK: begin
                if (w_qtick && phase_q == 2'd2 && w_sda_in) begin
                    ack_err_d = 1'b1;
                end
                if (w_bit_end) begin
                    bit_cnt_d = 3'd7;
                    if (state_q == ST_WR_ACK || ack_err_q) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = rw_q ? ST_RD : ST_WR;
                    end
                end
            end
            ST_RD_NACK: begin
                if (w_bit_end) begin
                    rdata_d = shreg_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Bus pins are decoded from the next state so they register in step with it.
        w_tx_byte = (state_d == ST_WR) ? wdata_d : {addr_d, rw_d};
        case (state_d)
            ST_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            ST_START: begin
                scl_d    = (phase_d != 2'd3);
                sda_oe_d = phase_d[1];
            end
            ST_ADDR, ST_WR: begin
                scl_d    = phase_d[0] ^ phase_d[1];
                sda_oe_d = ~w_tx_byte[bit_cnt_d];
            end
            ST_STOP: begin
                scl_d    = (phase_d != 2'd0);
                sda_oe_d = ~phase_d[1];
            end
            default: begin
                scl_d    = phase_d[0] ^ phase_d[1];
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= 2'd0;
            qcnt_q    <= '0;
            bit_cnt_q <= 3'd0;
            rw_q      <= 1'b0;
            addr_q    <= 7'h00;
            wdata_q   <= 8'h00;
            shreg_q   <= 8'h00;
            rdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            qcnt_q    <= qcnt_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shreg_q   <= shreg_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign SCL         = scl_q;
    assign SDA         = sda_oe_q ? 1'b0 : 1'bz;
    assign req.rdata   = rdata_q;
    assign req.busy    = busy_q;
    assign req.done    = done_q;
    assign req.ack_err = ack_err_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_controller.sv
// ============================================================================
// Module : tb_i2c_master_controller
// Brief  : Scoreboard bench with an I2C slave/IO-expander model on the bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_controller;

    localparam int         CLK_DIV  = 4;
    localparam int         LAT_FULL = 80 * CLK_DIV;
    localparam int         LAT_NACK = 44 * CLK_DIV;
    localparam logic [6:0] SLV_ADDR = 7'h27;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_master_controller_if bus_if ();
    wire  scl;
    wire  sda;
    logic slv_low = 1'b0;

    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus_if.slave),
        .SCL   (scl),
        .SDA   (sda)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard queue ----------------
    typedef struct {
        logic       ack_err;
        logic [7:0] rdata;
        int         lat;
        logic [7:0] io;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_io    = 8'h00;
    logic [7:0] model_rdata = 8'h00;

    function automatic void model_push(input logic rw, input logic [6:0] a, input logic [7:0] d);
        exp_t e;
        if (a == SLV_ADDR) begin
            e.ack_err = 1'b0;
            e.lat     = LAT_FULL;
            if (rw) model_rdata = model_io;
            else    model_io    = d;
        end else begin
            e.ack_err = 1'b1;
            e.lat     = LAT_NACK;
        end
        e.rdata = model_rdata;
        e.io    = model_io;
        exp_q.push_back(e);
    endfunction

    // ---------------- slave / IO-expander bus model ----------------
    localparam int SL_IDLE = 0, SL_ADDR = 1, SL_AACK = 2, SL_WR = 3, SL_WACK = 4, SL_RD = 5, SL_RACK = 6;
    int         slv_mode = SL_IDLE;
    int         slv_cnt  = 0;
    logic [7:0] slv_sh   = 8'h00;
    logic [7:0] slv_tx   = 8'h00;
    logic       slv_rd   = 1'b0;
    logic [7:0] slv_io   = 8'h00;
    logic       s_pscl   = 1'b1;
    logic       s_psda   = 1'b1;

    always @(negedge clk) begin
        if (scl && s_pscl && s_psda && !sda) begin
            slv_mode = SL_ADDR; slv_cnt = 0; slv_sh = 8'h00; slv_low = 1'b0;
        end else if (scl && s_pscl && !s_psda && sda) begin
            slv_mode = SL_IDLE; slv_low = 1'b0;
        end else if (scl && !s_pscl) begin
            if (slv_mode == SL_ADDR || slv_mode == SL_WR) begin
                slv_sh = {slv_sh[6:0], sda};
                slv_cnt++;
            end else if (slv_mode == SL_RACK) begin
                chk("master_nack_on_read", int'(sda), 1);
            end
        end else if (!scl && s_pscl) begin
            case (slv_mode)
                SL_ADDR: if (slv_cnt == 8) begin
                    if (slv_sh[7:1] == SLV_ADDR) begin
                        slv_rd = slv_sh[0]; slv_low = 1'b1; slv_mode = SL_AACK;
                    end else begin
                        slv_mode = SL_IDLE;
                    end
                end
                SL_AACK: begin
                    slv_cnt = 0; slv_sh = 8'h00;
                    if (slv_rd) begin
                        slv_tx = slv_io; slv_low = ~slv_tx[7]; slv_cnt = 1; slv_mode = SL_RD;
                    end else begin
                        slv_low = 1'b0; slv_mode = SL_WR;
                    end
                end
                SL_WR: if (slv_cnt == 8) begin
                    slv_io = slv_sh; slv_low = 1'b1; slv_mode = SL_WACK;
                end
                SL_WACK: begin slv_low = 1'b0; slv_mode = SL_IDLE; end
                SL_RD: begin
                    if (slv_cnt == 8) begin
                        slv_low = 1'b0; slv_mode = SL_RACK;
                    end else begin
                        slv_low = ~slv_tx[7 - slv_cnt]; slv_cnt++;
                    end
                end
                SL_RACK: slv_mode = SL_IDLE;
                default: ;
            endcase
        end
        s_pscl = scl;
        s_psda = sda;
    end

    // ---------------- scoreboard monitor ----------------
    int   lat       = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            lat = 0;
        end else begin
            if (bus_if.busy) lat++;
            if (bus_if.done) begin
                chk("done_single_cycle", int'(prev_done), 0);
                chk("busy_low_at_done", int'(bus_if.busy), 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got a done pulse, expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_err", int'(bus_if.ack_err), int'(e.ack_err));
                    chk("rdata", int'(bus_if.rdata), int'(e.rdata));
                    chk("latency", lat, e.lat);
                    chk("slave_io", int'(slv_io), int'(e.io));
                end
                lat = 0;
            end
        end
        prev_done = bus_if.done;
    end

    // ---------------- bus protocol monitor ----------------
    logic p_scl = 1'b1, p_sda = 1'b1, in_xfer = 1'b0, hi_valid = 1'b0;
    int   hi_cnt = 0, rises = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_xfer = 1'b0; hi_valid = 1'b0; rises = 0; hi_cnt = 0;
        end else begin
            if (scl && p_scl && (sda != p_sda)) begin
                if (!sda) begin
                    chk("start_legal", int'(in_xfer), 0);
                    in_xfer = 1'b1; rises = 0;
                end else begin
                    chk("stop_legal", int'(in_xfer && (rises == 10 || rises == 19)), 1);
                    in_xfer = 1'b0;
                end
                hi_valid = 1'b0;
            end
            if (scl && !p_scl) begin
                rises++; hi_cnt = 1; hi_valid = 1'b1;
            end else if (scl && p_scl) begin
                hi_cnt++;
            end
            if (!scl && p_scl && hi_valid) begin
                chk("scl_high_time", hi_cnt, 2 * CLK_DIV);
                hi_valid = 1'b0;
            end
        end
        p_scl = scl;
        p_sda = sda;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        while ((bus_if.busy || bus_if.done) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL issue_timeout: busy still 1, expected idle within 2000 cycles");
        end else begin
            model_push(rw, a, d);
            bus_if.start = 1'b1; bus_if.rw = rw; bus_if.addr = a; bus_if.wdata = d;
            @(posedge clk); #1;
            bus_if.start = 1'b0;
            chk("busy_rise", int'(bus_if.busy), 1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || bus_if.busy) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_scl"}, int'(scl), 1);
        chk({tag, "_sda"}, int'(sda), 1);
        chk({tag, "_busy"}, int'(bus_if.busy), 0);
    endtask

    initial begin
        bus_if.start = 1'b0; bus_if.rw = 1'b0; bus_if.addr = 7'h00; bus_if.wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_done", int'(bus_if.done), 0);
        chk("reset_ack_err", int'(bus_if.ack_err), 0);
        chk("reset_rdata", int'(bus_if.rdata), 0);
        rst_n = 1'b1;

        issue(1'b0, SLV_ADDR, 8'hA5);
        issue(1'b1, SLV_ADDR, 8'h00);
        issue(1'b0, 7'h28, 8'hC3);
        wait_idle();
        repeat (2) @(posedge clk); #1;
        check_idle_outputs("after_nack");

        // A second request mid-transfer must be ignored.
        issue(1'b0, SLV_ADDR, 8'h11);
        repeat (100) @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.wdata = 8'h3C;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_idle();

        // A request on the done clock must be ignored.
        issue(1'b0, SLV_ADDR, 8'h42);
        begin
            int n = 0;
            while (!bus_if.done && n < 2000) begin @(posedge clk); #1; n++; end
            chk("done_seen", int'(bus_if.done), 1);
        end
        bus_if.start = 1'b1; bus_if.rw = 1'b0; bus_if.addr = SLV_ADDR; bus_if.wdata = 8'h99;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        chk("start_on_done_ignored", int'(bus_if.busy), 0);
        wait_idle();

        // Reset during address bit 3 (SCL low phase).
        issue(1'b0, SLV_ADDR, 8'h77);
        repeat (81) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        chk("midreset_done", int'(bus_if.done), 0);
        chk("midreset_ack_err", int'(bus_if.ack_err), 0);
        chk("midreset_rdata", int'(bus_if.rdata), 0);
        exp_q.delete();
        model_rdata = 8'h00;
        rst_n = 1'b1;
        issue(1'b0, SLV_ADDR, 8'h5A);
        issue(1'b1, SLV_ADDR, 8'h00);

        for (int i = 0; i < 10; i++) begin
            logic       r;
            logic [6:0] a;
            logic [7:0] d;
            r = 1'($urandom_range(0, 1));
            a = SLV_ADDR;
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom);
                if (a == SLV_ADDR) a = a ^ 7'h01;
            end
            d = 8'($urandom);
            issue(r, a, d);
        end
        wait_idle();
        repeat (4) @(posedge clk); #1;
        check_idle_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
